// File: rtl/button_event_pkg.sv
// button_pkg: shared types and default timing constants for the button
// event block.
//   state_t      - press-classifier FSM states (IDLE, SHORT, LONG)
//   TICK_DIV     - default clock cycles per timing tick
//   LONG_TICKS   - default ticks of hold before a long-press
//   REPEAT_TICKS - default ticks between auto-repeat pulses
package button_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHORT = 2'd1,
    LONG  = 2'd2
  } state_t;

  localparam int TICK_DIV     = 100000;
  localparam int LONG_TICKS   = 100;
  localparam int REPEAT_TICKS = 20;

endpackage

// File: rtl/button_event_tick_divider.sv
// tick_divider: free-running modulo-TICK_DIV counter producing the timing
// tick for the button event block.
//   clk   - system clock
//   reset - synchronous, active-high reset
//   clear - restart the count at 0 on the next edge (press re-phasing)
//   tick  - high while the count sits at TICK_DIV-1
module tick_divider #(
  parameter int TICK_DIV = button_pkg::TICK_DIV
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);
  import button_pkg::*;

  localparam int CW = $clog2(TICK_DIV);

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (reset || clear) cnt <= '0;
    else if (tick)      cnt <= '0;
    else                cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/button_event.sv
// button_event: turns a debounced button level into press/release strobes,
// short/long press classification, optional auto-repeat and a press count.
//   clk           - system clock
//   reset         - synchronous, active-high reset
//   but_in        - debounced button level, 1 = pressed
//   press_pulse   - 1-cycle strobe, cycle after a press edge
//   release_pulse - 1-cycle strobe, cycle after a release edge
//   short_pulse   - 1-cycle strobe on a release before the long threshold
//   long_pulse    - 1-cycle strobe, LONG_TICKS*TICK_DIV cycles after press_pulse
//   repeat_pulse  - 1-cycle auto-repeat strobe while held long
//   held          - level, high while in LONG
//   press_count   - 8-bit wrapping press counter
// Build option: define BUTTON_EVENT_REPEAT_EN to enable auto-repeat; without
// it repeat_pulse is tied low and no repeat counter is built.
module button_event #(
  parameter int TICK_DIV     = button_pkg::TICK_DIV,
  parameter int LONG_TICKS   = button_pkg::LONG_TICKS,
  parameter int REPEAT_TICKS = button_pkg::REPEAT_TICKS
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       but_in,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       short_pulse,
  output logic       long_pulse,
  output logic       repeat_pulse,
  output logic       held,
  output logic [7:0] press_count
);
  import button_pkg::*;

  localparam int HW = $clog2(LONG_TICKS + 1);

  if (TICK_DIV < 2 || LONG_TICKS < 1 || REPEAT_TICKS < 1) begin : g_bad_param
    $error("button_event: illegal timing parameters");
  end

  state_t        state, state_nxt;
  logic          in_q;
  logic          press_edge, rel_edge, tick;
  logic [HW-1:0] hold_cnt, hold_nxt;
  logic          short_nxt, long_nxt;

  assign press_edge = but_in & ~in_q;
  assign rel_edge   = ~but_in & in_q;

  // Clearing on the press edge puts the divider at 0 during the press_pulse
  // cycle, so tick k lands exactly k*TICK_DIV-1 cycles after press_pulse.
  tick_divider #(.TICK_DIV(TICK_DIV)) u_div (
    .clk   (clk),
    .reset (reset),
    .clear (press_edge),
    .tick  (tick)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    short_nxt = 1'b0;
    long_nxt  = 1'b0;
    if (press_edge) begin
      // Any press edge (even outside IDLE) restarts classification.
      state_nxt = SHORT;
      hold_nxt  = '0;
    end else begin
      case (state)
        SHORT: begin
          // Release has priority over a threshold tick in the same cycle.
          if (rel_edge) begin
            state_nxt = IDLE;
            short_nxt = 1'b1;
          end else if (tick) begin
            hold_nxt = hold_cnt + 1'b1;
            if (hold_cnt == HW'(LONG_TICKS - 1)) begin
              state_nxt = LONG;
              long_nxt  = 1'b1;
            end
          end
        end
        LONG: if (rel_edge) state_nxt = IDLE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      in_q          <= 1'b0;
      hold_cnt      <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      short_pulse   <= 1'b0;
      long_pulse    <= 1'b0;
      press_count   <= '0;
    end else begin
      in_q          <= but_in;
      hold_cnt      <= hold_nxt;
      press_pulse   <= press_edge;
      release_pulse <= rel_edge;
      short_pulse   <= short_nxt;
      long_pulse    <= long_nxt;
      if (press_edge) press_count <= press_count + 8'd1;
    end
  end

  assign held = (state == LONG);

`ifdef BUTTON_EVENT_REPEAT_EN
  localparam int RW = $clog2(REPEAT_TICKS + 1);

  logic [RW-1:0] rpt_cnt;
  logic          rpt_q;

  // rpt_cnt sits at 0 on LONG entry; the divider keeps its phase from the
  // press, so repeats land REPEAT_TICKS*TICK_DIV apart from long_pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      rpt_cnt <= '0;
      rpt_q   <= 1'b0;
    end else begin
      rpt_q <= 1'b0;
      if (state != LONG || press_edge || rel_edge) begin
        rpt_cnt <= '0;
      end else if (tick) begin
        if (rpt_cnt == RW'(REPEAT_TICKS - 1)) begin
          rpt_cnt <= '0;
          rpt_q   <= 1'b1;
        end else begin
          rpt_cnt <= rpt_cnt + 1'b1;
        end
      end
    end
  end

  assign repeat_pulse = rpt_q;
`else
  assign repeat_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_button_event.sv
// tb_button_event: directed plus randomized stimulus against a reference
// model that tracks "cycles since press_pulse" and derives every expected
// strobe from the timing rules (TICK_DIV=4, LONG_TICKS=3, REPEAT_TICKS=2).
module tb_button_event;

  localparam int D  = 4;
  localparam int LT = 3;
  localparam int RT = 2;
  localparam int LD = LT * D;
  localparam int RD = RT * D;
`ifdef BUTTON_EVENT_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       but_in;
  logic       press_pulse, release_pulse, short_pulse, long_pulse;
  logic       repeat_pulse, held;
  logic [7:0] press_count;

  button_event #(.TICK_DIV(D), .LONG_TICKS(LT), .REPEAT_TICKS(RT)) dut (
    .clk           (clk),
    .reset         (reset),
    .but_in        (but_in),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .short_pulse   (short_pulse),
    .long_pulse    (long_pulse),
    .repeat_pulse  (repeat_pulse),
    .held          (held),
    .press_count   (press_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: last sampled level, whether a press is being timed,
  // and k = cycles elapsed since the press_pulse cycle.
  bit       m_prev, m_active;
  int       m_k;
  bit [7:0] m_cnt;
  bit       e_press, e_rel, e_short, e_long, e_rep, e_held;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model(input bit b, input bit r);
    bit rise, fall;
    {e_press, e_rel, e_short, e_long, e_rep, e_held} = '0;
    if (r) begin
      m_prev = 1'b0; m_active = 1'b0; m_k = 0; m_cnt = '0;
      return;
    end
    rise   = b & ~m_prev;
    fall   = ~b & m_prev;
    m_prev = b;
    e_press = rise;
    e_rel   = fall;
    if (rise) begin
      m_active = 1'b1;
      m_k      = 0;
      m_cnt    = m_cnt + 8'd1;
    end else if (m_active) begin
      m_k++;
      if (fall) begin
        e_short  = (m_k <= LD);
        m_active = 1'b0;
      end else begin
        e_long = (m_k == LD);
        e_held = (m_k >= LD);
        e_rep  = REP_EN && (m_k > LD) && ((m_k - LD) % RD == 0);
      end
    end
  endtask

  task automatic step(input bit b, input bit r);
    @(negedge clk);
    but_in = b;
    reset  = r;
    @(posedge clk);
    model(b, r);
    #1;
    chk("press_pulse",   {7'd0, press_pulse},   {7'd0, e_press});
    chk("release_pulse", {7'd0, release_pulse}, {7'd0, e_rel});
    chk("short_pulse",   {7'd0, short_pulse},   {7'd0, e_short});
    chk("long_pulse",    {7'd0, long_pulse},    {7'd0, e_long});
    chk("repeat_pulse",  {7'd0, repeat_pulse},  {7'd0, e_rep});
    chk("held",          {7'd0, held},          {7'd0, e_held});
    chk("press_count",   press_count,           m_cnt);
  endtask

  task automatic hold(input bit b, input int n);
    for (int i = 0; i < n; i++) step(b, 1'b0);
  endtask

  initial begin
    reset  = 1'b1;
    but_in = 1'b0;
    m_prev = 1'b0; m_active = 1'b0; m_k = 0; m_cnt = '0;

    // Reset state
    repeat (3) step(1'b0, 1'b1);

    // Short press: 5 cycles high
    hold(1'b1, 5);
    hold(1'b0, 6);
    chk("short_count", press_count, 8'd1);

    // Long press: 20 cycles held
    hold(1'b1, 20);
    hold(1'b0, 6);

    // Repeat window: 30 cycles held
    hold(1'b1, 30);
    hold(1'b0, 12);

    // Coincidence: release lands on the long-threshold cycle
    hold(1'b1, 12);
    hold(1'b0, 6);

    // Wrap: 256 presses from a clean reset
    step(1'b0, 1'b1);
    for (int i = 0; i < 256; i++) begin
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
    end
    chk("wrap_count", press_count, 8'd0);

    // Reset at press+6 with the button still down, then keep holding
    hold(1'b1, 7);
    step(1'b1, 1'b1);
    hold(1'b1, 8);
    hold(1'b0, 5);

    // Randomized presses with occasional mid-press reset
    for (int n = 0; n < 60; n++) begin
      int len, gap, rst_at;
      len    = $urandom_range(1, 40);
      gap    = $urandom_range(1, 8);
      rst_at = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, len - 1)) : -1;
      for (int i = 0; i < len; i++) step(1'b1, i == rst_at);
      hold(1'b0, gap);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/button_event.md
BUTTON_EVENT -- requirements
Module: button_event

Interface
REQ-001 Parameter TICK_DIV, default 100000: clock cycles per timing tick; legal values are 2 or more.
REQ-002 Parameter LONG_TICKS, default 100: ticks of continuous hold before a long-press is declared; legal values are 1 or more.
REQ-003 Parameter REPEAT_TICKS, default 20: ticks between auto-repeat pulses; legal values are 1 or more.
REQ-004 Ports SHALL be (clock and reset first):
 clk  input  1  system clock; the one clock domain.
 reset  input  1  synchronous, active-high reset.
 but_in  input  1  debounced button level from the upstream debouncer; 1 = pressed.
 press_pulse  output  1  one-cycle strobe on press.
 release_pulse  output  1  one-cycle strobe on release.
 short_pulse  output  1  one-cycle strobe when a release comes before the long threshold.
 long_pulse  output  1  one-cycle strobe when the long threshold is reached.
 repeat_pulse  output  1  one-cycle auto-repeat strobe.
 held  output  1  level; high while in the LONG state.
 press_count  output  8  count of presses, wraps.

Function
REQ-005 but_in SHALL be registered into in_q; edge detection SHALL use but_in versus in_q.
REQ-006 Press edge (but_in=1, in_q=0): press_pulse SHALL be high for exactly the next cycle (1-cycle latency); press_count SHALL increment in the same cycle.
REQ-007 press_count SHALL wrap from 255 to 0 with no flag.
REQ-008 FSM states and transitions:
 IDLE -> SHORT on a press edge.
 SHORT -> IDLE on a release edge.
 SHORT -> LONG when hold_cnt reaches LONG_TICKS.
 LONG -> IDLE on a release edge.
REQ-009 Tick divider: counts 0..TICK_DIV-1 and asserts tick when at TICK_DIV-1; it SHALL be cleared to 0 in the press_pulse cycle.
REQ-010 hold_cnt SHALL be cleared on a press edge and increment on each tick in SHORT.
REQ-011 Long-press timing: long_pulse SHALL assert exactly LONG_TICKS*TICK_DIV cycles after press_pulse, once per press.
REQ-012 Release edge in SHORT: release_pulse and short_pulse SHALL both be high in the same single cycle.
REQ-013 Release edge in LONG: release_pulse only; no short_pulse.
REQ-014 Release edge coinciding with the long threshold: the release wins; short_pulse and release_pulse assert, long_pulse does not, and the next state is IDLE.
REQ-015 held SHALL be 1 in LONG, otherwise 0.
REQ-016 All pulse outputs SHALL be registered; no output SHALL be combinational from but_in.
REQ-017 A press edge outside IDLE cannot occur; the FSM SHALL treat one as a restart into SHORT.

Reset
REQ-018 With reset high at a clk edge, all of the following SHALL be 0:
 state (IDLE), in_q, divider, hold_cnt, rpt_cnt
 all pulse outputs, held, press_count
REQ-019 Reset SHALL override all other events in the same cycle.
REQ-020 Reset mid-operation SHALL abort any pending long or repeat pulse.
REQ-021 If but_in is held high through reset deassertion, press_pulse SHALL fire in the cycle after the first post-reset edge (in_q resets to 0).

Configuration
REQ-022 Macro BUTTON_EVENT_REPEAT_EN, when defined:
 in LONG, rpt_cnt counts ticks.
 repeat_pulse asserts every REPEAT_TICKS*TICK_DIV cycles after long_pulse until release.
 The divider is not cleared at long_pulse; phase continues.
REQ-023 Without BUTTON_EVENT_REPEAT_EN, repeat_pulse SHALL be tied 0 and rpt_cnt SHALL not exist.

Structure
REQ-024 Package button_pkg SHALL hold the FSM state typedef (IDLE, SHORT, LONG) and the default constants TICK_DIV, LONG_TICKS and REPEAT_TICKS.
REQ-025 Sub-module tick_divider SHALL provide the clear input, tick output and TICK_DIV parameter.
REQ-026 The FSM, counters and pulse registers SHALL be in button_event.

Verification (TICK_DIV=4, LONG_TICKS=3, REPEAT_TICKS=2)
REQ-027 Short press:
 stimulus: but_in high 5 cycles, then low.
 response: press_pulse 1 cycle; press_count=1; short_pulse and release_pulse together; no long_pulse.
REQ-028 Long press:
 stimulus: but_in held 20 cycles.
 response: long_pulse exactly 12 cycles after press_pulse; held=1 until release; release_pulse only on release.
REQ-029 Repeat (macro defined):
 stimulus: hold 30 cycles.
 response: repeat_pulse at press+20 and press+28; none after release.
 Without the macro: repeat_pulse stays 0.
REQ-030 Coincidence:
 stimulus: release edge such that it lands in the cycle long would fire (press+12).
 response: short_pulse and release_pulse; no long_pulse.
REQ-031 Wrap and reset:
 stimulus: 256 presses.
 response: press_count=0.
 stimulus: reset at press+6.
 response: all outputs 0; no long_pulse afterwards; but_in still high gives press_pulse after reset deasserts.
